// File: rtl/reference_model.sv
// Register-access decoder for a DMA controller: turns CPU read/write strobes into read levels,
// one-cycle write pulses, the addressed channel and the low/high byte-pointer flip-flop.
module reference_model (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS_N,
    input  logic       IOR_N,
    input  logic       IOW_N,
    input  logic       A3,
    input  logic       A2,
    input  logic       A1,
    input  logic       A0,
    input  logic       programCondition,
    output logic       readStatusReg,
    output logic       loadIoDataBufferFromStatus,
    output logic       readCurrentAddressReg,
    output logic       readCurrentWordCountReg,
    output logic       readTempReg,
    output logic       loadCommandReg,
    output logic       loadModeReg,
    output logic       loadRequestReg,
    output logic       loadSingleMask,
    output logic       loadAllMask,
    output logic       clearMaskReg,
    output logic       masterClear,
    output logic       clearInternalFF,
    output logic       loadBaseAddressReg,
    output logic       loadBaseWordCountReg,
    output logic [1:0] channelSel,
    output logic       internalFF
);

    typedef enum logic [0:0] {ReadIdle, ReadHeld} readStateT;

    logic [3:0] addr;
    logic       qual;
    logic       bothLow;
    logic       outEnable;
    logic       readCycle;

    assign addr      = {A3, A2, A1, A0};
    assign qual      = !CS_N && programCondition;
    assign bothLow   = !IOR_N && !IOW_N;
    assign outEnable = qual && !bothLow && !RESET;
    assign readCycle = outEnable && !IOR_N;

    // Write-side state
    logic       iowPrev;
    logic       writeArmed;
    logic       pulseValid;
    logic [3:0] pulseAddr;
    logic       writeStart;
    logic       pulseActive;

    // writeArmed blocks a strobe that was already low when reset released.
    assign writeStart  = qual && !IOW_N && iowPrev && IOR_N && writeArmed;
    assign pulseActive = pulseValid && outEnable;

    // Read-side tracking
    readStateT readState;
    readStateT readStateNext;
    logic      readStart;
    logic      readEnd;

    logic chLoad;
    logic ffClear;
    logic ffToggle;

    always_comb begin
        readStatusReg              = 1'b0;
        loadIoDataBufferFromStatus = 1'b0;
        readCurrentAddressReg      = 1'b0;
        readCurrentWordCountReg    = 1'b0;
        readTempReg                = 1'b0;
        if (readCycle) begin
            if (addr == 4'b1000) begin
                readStatusReg              = 1'b1;
                loadIoDataBufferFromStatus = 1'b1;
            end
            if (!A3) begin
                readCurrentAddressReg   = !A0;
                readCurrentWordCountReg = A0;
            end
            if (addr == 4'b1101) begin
                readTempReg = 1'b1;
            end
        end
    end

    always_comb begin
        loadCommandReg       = 1'b0;
        loadModeReg          = 1'b0;
        loadRequestReg       = 1'b0;
        loadSingleMask       = 1'b0;
        loadAllMask          = 1'b0;
        clearMaskReg         = 1'b0;
        masterClear          = 1'b0;
        clearInternalFF      = 1'b0;
        loadBaseAddressReg   = 1'b0;
        loadBaseWordCountReg = 1'b0;
        if (pulseActive) begin
            if (!pulseAddr[3]) begin
                loadBaseAddressReg   = !pulseAddr[0];
                loadBaseWordCountReg = pulseAddr[0];
            end else begin
                unique case (pulseAddr[2:0])
                    3'b000: loadCommandReg  = 1'b1;
                    3'b001: loadRequestReg  = 1'b1;
                    3'b010: loadSingleMask  = 1'b1;
                    3'b011: loadModeReg     = 1'b1;
                    3'b100: clearInternalFF = 1'b1;
                    3'b101: masterClear     = 1'b1;
                    3'b110: clearMaskReg    = 1'b1;
                    3'b111: loadAllMask     = 1'b1;
                endcase
            end
        end
    end

    // A read of an address/count register holds the byte pointer until IOR_N is seen high.
    always_comb begin
        readStateNext = readState;
        readStart     = 1'b0;
        readEnd       = 1'b0;
        unique case (readState)
            ReadIdle: begin
                if (readCycle && !A3) begin
                    readStart     = 1'b1;
                    readStateNext = ReadHeld;
                end
            end
            ReadHeld: begin
                if (IOR_N) begin
                    readEnd       = 1'b1;
                    readStateNext = ReadIdle;
                end
            end
        endcase
    end

    assign chLoad   = (writeStart && !A3) || readStart;
    assign ffClear  = clearInternalFF || masterClear;
    assign ffToggle = (pulseActive && !pulseAddr[3]) || readEnd;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            iowPrev    <= 1'b1;
            writeArmed <= 1'b0;
            pulseValid <= 1'b0;
            pulseAddr  <= 4'b0000;
            readState  <= ReadIdle;
            channelSel <= 2'b00;
            internalFF <= 1'b0;
        end else begin
            iowPrev    <= IOW_N;
            pulseValid <= writeStart;
            readState  <= readStateNext;
            if (IOW_N) begin
                writeArmed <= 1'b1;
            end
            if (writeStart) begin
                pulseAddr <= addr;
            end
            if (chLoad) begin
                channelSel <= {A2, A1};
            end
            if (ffClear) begin
                internalFF <= 1'b0;
            end else if (ffToggle) begin
                internalFF <= ~internalFF;
            end
        end
    end

endmodule

// File: tb/tb_reference_model.sv
// Directed-vector bench for reference_model: write pulses, read levels, byte pointer, reset.
module tb_reference_model;

    logic       CLK;
    logic       RESET;
    logic       CS_N;
    logic       IOR_N;
    logic       IOW_N;
    logic       A3, A2, A1, A0;
    logic       programCondition;
    logic       readStatusReg, loadIoDataBufferFromStatus, readCurrentAddressReg;
    logic       readCurrentWordCountReg, readTempReg;
    logic       loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask;
    logic       clearMaskReg, masterClear, clearInternalFF, loadBaseAddressReg;
    logic       loadBaseWordCountReg;
    logic [1:0] channelSel;
    logic       internalFF;

    int numCompared   = 0;
    int numMismatched = 0;

    localparam logic [9:0] PNone     = 10'h000;
    localparam logic [9:0] PCmd      = 10'h200;
    localparam logic [9:0] PMode     = 10'h100;
    localparam logic [9:0] PReq      = 10'h080;
    localparam logic [9:0] PSingle   = 10'h040;
    localparam logic [9:0] PAll      = 10'h020;
    localparam logic [9:0] PClrMask  = 10'h010;
    localparam logic [9:0] PMaster   = 10'h008;
    localparam logic [9:0] PClrFf    = 10'h004;
    localparam logic [9:0] PBaseAddr = 10'h002;
    localparam logic [9:0] PBaseCnt  = 10'h001;

    localparam logic [4:0] RNone   = 5'b00000;
    localparam logic [4:0] RStatus = 5'b11000;
    localparam logic [4:0] RAddr   = 5'b00100;
    localparam logic [4:0] RCount  = 5'b00010;
    localparam logic [4:0] RTemp   = 5'b00001;

    logic [9:0] pulses;
    logic [4:0] reads;

    assign pulses = {loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask,
                     clearMaskReg, masterClear, clearInternalFF, loadBaseAddressReg,
                     loadBaseWordCountReg};
    assign reads  = {readStatusReg, loadIoDataBufferFromStatus, readCurrentAddressReg,
                     readCurrentWordCountReg, readTempReg};

    reference_model dut (
        .CLK                        (CLK),
        .RESET                      (RESET),
        .CS_N                       (CS_N),
        .IOR_N                      (IOR_N),
        .IOW_N                      (IOW_N),
        .A3                         (A3),
        .A2                         (A2),
        .A1                         (A1),
        .A0                         (A0),
        .programCondition           (programCondition),
        .readStatusReg              (readStatusReg),
        .loadIoDataBufferFromStatus (loadIoDataBufferFromStatus),
        .readCurrentAddressReg      (readCurrentAddressReg),
        .readCurrentWordCountReg    (readCurrentWordCountReg),
        .readTempReg                (readTempReg),
        .loadCommandReg             (loadCommandReg),
        .loadModeReg                (loadModeReg),
        .loadRequestReg             (loadRequestReg),
        .loadSingleMask             (loadSingleMask),
        .loadAllMask                (loadAllMask),
        .clearMaskReg               (clearMaskReg),
        .masterClear                (masterClear),
        .clearInternalFF            (clearInternalFF),
        .loadBaseAddressReg         (loadBaseAddressReg),
        .loadBaseWordCountReg       (loadBaseWordCountReg),
        .channelSel                 (channelSel),
        .internalFF                 (internalFF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic setAddr(input logic [3:0] a);
        {A3, A2, A1, A0} = a;
    endtask

    // Entered mid-cycle; IOW_N low for lowCycles edges, pulse checked after the start edge.
    task automatic writeCycle(input logic [3:0] a, input int lowCycles, input logic [9:0] expPulse,
                              input logic expFf, input logic [1:0] expCh, input string tag);
        setAddr(a);
        IOW_N = 1'b0;
        for (int i = 0; i < lowCycles; i++) begin
            @(posedge CLK);
            #3;
            checkEq({tag, ".pulse"}, 32'(pulses), (i == 0) ? 32'(expPulse) : 32'(PNone));
        end
        IOW_N = 1'b1;
        @(posedge CLK);
        #2;
        checkEq({tag, ".after"}, 32'(pulses), 32'(PNone));
        checkEq({tag, ".ff"}, 32'(internalFF), 32'(expFf));
        checkEq({tag, ".ch"}, 32'(channelSel), 32'(expCh));
    endtask

    task automatic readCycle(input logic [3:0] a, input int lowCycles, input logic [4:0] expRead,
                             input logic ffDuring, input logic ffAfter, input logic [1:0] expCh,
                             input string tag);
        setAddr(a);
        IOR_N = 1'b0;
        #1;
        checkEq({tag, ".level"}, 32'(reads), 32'(expRead));
        for (int i = 0; i < lowCycles; i++) begin
            @(posedge CLK);
            #3;
            checkEq({tag, ".hold"}, 32'(reads), 32'(expRead));
            checkEq({tag, ".ffHold"}, 32'(internalFF), 32'(ffDuring));
        end
        IOR_N = 1'b1;
        @(posedge CLK);
        #2;
        checkEq({tag, ".ffAfter"}, 32'(internalFF), 32'(ffAfter));
        checkEq({tag, ".ch"}, 32'(channelSel), 32'(expCh));
    endtask

    initial begin
        RESET = 1'b1;
        CS_N = 1'b1;
        IOR_N = 1'b1;
        IOW_N = 1'b1;
        programCondition = 1'b0;
        setAddr(4'b0000);
        @(posedge CLK);
        #2;
        checkEq("rst.pulses", 32'(pulses), 32'(PNone));
        checkEq("rst.ff", 32'(internalFF), 32'd0);
        checkEq("rst.ch", 32'(channelSel), 32'd0);

        // Read decode forced off while RESET is high even with a qualified read.
        CS_N = 1'b0;
        programCondition = 1'b1;
        setAddr(4'b1000);
        IOR_N = 1'b0;
        #1;
        checkEq("rst.readGated", 32'(reads), 32'(RNone));
        IOR_N = 1'b1;

        // IOW_N already low across reset release must not pulse.
        IOW_N = 1'b0;
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #3;
            checkEq("rstRelease.noPulse", 32'(pulses), 32'(PNone));
        end
        IOW_N = 1'b1;
        @(posedge CLK);
        #2;

        writeCycle(4'b1000, 3, PCmd, 1'b0, 2'b00, "cmd3cyc");
        writeCycle(4'b0010, 1, PBaseAddr, 1'b1, 2'b01, "baseA1");
        writeCycle(4'b0010, 1, PBaseAddr, 1'b0, 2'b01, "baseA2");
        writeCycle(4'b0000, 1, PBaseAddr, 1'b1, 2'b00, "baseA0");
        writeCycle(4'b1100, 1, PClrFf, 1'b0, 2'b00, "clrFf");
        writeCycle(4'b1001, 1, PReq, 1'b0, 2'b00, "req");
        writeCycle(4'b1010, 2, PSingle, 1'b0, 2'b00, "single");
        writeCycle(4'b1011, 1, PMode, 1'b0, 2'b00, "mode");
        writeCycle(4'b0111, 1, PBaseCnt, 1'b1, 2'b11, "baseCnt3");
        writeCycle(4'b1101, 1, PMaster, 1'b0, 2'b11, "master");
        writeCycle(4'b1110, 1, PClrMask, 1'b0, 2'b11, "clrMask");
        writeCycle(4'b1111, 1, PAll, 1'b0, 2'b11, "allMask");

        readCycle(4'b1000, 3, RStatus, 1'b0, 1'b0, 2'b11, "rdStatus");
        readCycle(4'b0100, 2, RAddr, 1'b0, 1'b1, 2'b10, "rdAddr2");
        readCycle(4'b0111, 2, RCount, 1'b1, 1'b0, 2'b11, "rdCnt3");
        readCycle(4'b1101, 1, RTemp, 1'b0, 1'b0, 2'b11, "rdTemp");

        // Unqualified accesses: no decode, no pointer or channel change.
        CS_N = 1'b1;
        readCycle(4'b0000, 1, RNone, 1'b0, 1'b0, 2'b11, "rdNoCs");
        writeCycle(4'b0000, 1, PNone, 1'b0, 2'b11, "wrNoCs");
        CS_N = 1'b0;
        programCondition = 1'b0;
        readCycle(4'b1000, 1, RNone, 1'b0, 1'b0, 2'b11, "rdNoPc");
        writeCycle(4'b1000, 1, PNone, 1'b0, 2'b11, "wrNoPc");
        programCondition = 1'b1;

        // Both strobes low together is ignored.
        setAddr(4'b1011);
        IOR_N = 1'b0;
        IOW_N = 1'b0;
        #1;
        checkEq("bothLow.read", 32'(reads), 32'(RNone));
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #3;
            checkEq("bothLow.pulse", 32'(pulses), 32'(PNone));
            checkEq("bothLow.readHeld", 32'(reads), 32'(RNone));
        end
        IOR_N = 1'b1;
        IOW_N = 1'b1;
        @(posedge CLK);
        #2;
        checkEq("bothLow.after", 32'(pulses), 32'(PNone));

        // Async reset in the middle of a write pulse.
        writeCycle(4'b0001, 1, PBaseCnt, 1'b1, 2'b00, "preRst");
        setAddr(4'b0110);
        IOW_N = 1'b0;
        @(posedge CLK);
        #3;
        checkEq("midRst.pulse", 32'(pulses), 32'(PBaseAddr));
        checkEq("midRst.ch", 32'(channelSel), 32'd3);
        checkEq("midRst.ffBefore", 32'(internalFF), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        checkEq("midRst.pulseDrop", 32'(pulses), 32'(PNone));
        checkEq("midRst.ffDrop", 32'(internalFF), 32'd0);
        checkEq("midRst.chDrop", 32'(channelSel), 32'd0);
        IOW_N = 1'b1;
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
